// File: rtl/ecc_trace_player.sv
// Trace replayer: DEPTH x WIDTH stimulus memory streamed over valid/ready, one-shot or looping.
// Optional beat corruption is compiled in with the TRACE_ERR_INJECT_EN macro.
module ecc_trace_player #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [IDX_W:0]   len,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic [WIDTH-1:0] stim_data,
  output logic [IDX_W-1:0] stim_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      wraps,
  output logic [CNT_W-1:0] cycles,
  input  logic             inj_arm,
  input  logic [IDX_W-1:0] inj_step,
  input  logic [WIDTH-1:0] inj_mask,
  output logic             inj_fired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  logic [IDX_W:0]   r_len;
  logic             r_loop;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_wraps;
  logic [CNT_W-1:0] r_cycles;
  logic             r_inj_done;
  logic             r_inj_fired;

  logic [IDX_W:0]   w_len_clamp;
  logic             w_last;
  logic             w_accept;
  logic             w_wr_ok;
  logic             w_inj;
  logic [WIDTH-1:0] w_rd;

  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_last      = ({1'b0, r_idx} == (r_len - ONE_L));
  assign w_accept    = r_valid && stim_ready;
  assign w_wr_ok     = wr_en && (r_state != S_RUN) && ({1'b0, wr_addr} < DEPTH_L);
  assign w_rd        = r_mem[r_idx];

`ifdef TRACE_ERR_INJECT_EN
  // Corruption applies until the first acceptance of the targeted beat after start.
  assign w_inj = r_valid && inj_arm && !r_inj_done && (r_idx == inj_step);
`else
  logic w_unused_inj;
  assign w_unused_inj = inj_arm ^ (^inj_step) ^ (^inj_mask);
  assign w_inj        = 1'b0;
`endif

  assign stim_data  = r_valid ? (w_rd ^ (w_inj ? inj_mask : {WIDTH{1'b0}})) : {WIDTH{1'b0}};
  assign stim_valid = r_valid;
  assign stim_idx   = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wraps      = r_wraps;
  assign cycles     = r_cycles;
  assign inj_fired  = r_inj_fired;

  // Trace memory: no reset, writable only outside RUN.
  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Replay FSM with stop > start > handshake priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= {(IDX_W+1){1'b0}};
      r_loop      <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wraps     <= 16'd0;
      r_cycles    <= {CNT_W{1'b0}};
      r_inj_done  <= 1'b0;
      r_inj_fired <= 1'b0;
    end else begin
      r_inj_fired <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (start && (r_state != S_RUN)) begin
        r_len      <= w_len_clamp;
        r_loop     <= loop;
        r_idx      <= {IDX_W{1'b0}};
        r_cycles   <= {CNT_W{1'b0}};
        r_wraps    <= 16'd0;
        r_inj_done <= 1'b0;
        if (w_len_clamp == {(IDX_W+1){1'b0}}) begin
          r_state <= S_DONE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        if (r_cycles != {CNT_W{1'b1}}) begin
          r_cycles <= r_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (w_accept) begin
          if (w_inj) begin
            r_inj_done  <= 1'b1;
            r_inj_fired <= 1'b1;
          end
          if (!w_last) begin
            r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end else if (r_loop) begin
            r_idx <= {IDX_W{1'b0}};
            if (r_wraps != 16'hFFFF) begin
              r_wraps <= r_wraps + 16'd1;
            end
          end else begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
